ifetch_unit: RTL

Instruction fetch unit feeding the decode/control stage of the RV32I core. It owns the program counter, issues word reads to instruction memory over a request/grant interface, and buffers returned words in a small prefetch FIFO. It presents them to decode with a valid/ready handshake. It accepts PC redirects, asserted when decode selects a jump or taken branch, and discards stale prefetched and in-flight instructions.

---
 rtl/ifetch_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - RV32I instruction fetch unit with prefetch FIFO and PC redirect
//
// Owns the fetch PC, issues word reads over a req/gnt interface with in-order
// responses, buffers returned words (with their PCs) in a DEPTH-entry FIFO and
// hands them to decode over a valid/ready handshake.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     FIFO entries and maximum outstanding requests (power of 2, >= 2)
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt         request channel (word-aligned address)
//   imem_rvalid/imem_rdata              in-order read response
//   instr_valid/instr_ready/instr/instr_pc  decode handshake
//   redirect/redirect_pc                non-sequential PC from decode
//   fetch_fault                         misaligned redirect target, fetch halted
//
// Optional feature (macro IFETCH_BYPASS_EN): a kept response arriving while the
// FIFO is empty is presented to decode combinationally in the same cycle.

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     resp_pc_q;      // PC of the next response that will be kept
    logic [31:0]     last_instr_q;
    logic [31:0]     last_pc_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]     mem_instr [DEPTH];
    logic [31:0]     mem_pc    [DEPTH];

    logic            fifo_empty;
    logic            credit_ok;
    logic            grant;
    logic            keep;
    logic            bypass;
    logic            bypass_taken;
    logic            push;
    logic            pop;

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
        end
    end

    always_comb begin
        fifo_empty = (count_q == '0);
        // Credit counts buffered words plus words still in flight, so a
        // returning response always has a free FIFO slot.
        credit_ok  = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C;
        imem_req   = rst_n && (state_q == RUN) && credit_ok;
        imem_addr  = fetch_pc_q;
        grant      = imem_req && imem_gnt;
        keep       = imem_rvalid && (discard_q == '0) && !redirect && (state_q == RUN);
`ifdef IFETCH_BYPASS_EN
        bypass     = keep && fifo_empty;
`else
        bypass     = 1'b0;
`endif
        instr_valid = rst_n && (state_q == RUN) && (!fifo_empty || bypass);
        if (!fifo_empty) begin
            instr    = mem_instr[rd_ptr_q];
            instr_pc = mem_pc[rd_ptr_q];
        end else if (bypass) begin
            instr    = imem_rdata;
            instr_pc = resp_pc_q;
        end else begin
            instr    = last_instr_q;
            instr_pc = last_pc_q;
        end
        pop          = instr_valid && instr_ready && !fifo_empty;
        bypass_taken = bypass && instr_ready;
        push         = keep && !bypass_taken;
        case ({grant, imem_rvalid})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    assign fetch_fault = (state_q == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            last_instr_q <= 32'h0000_0013;
            last_pc_q    <= 32'h0000_0000;
            count_q      <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            outst_q <= outst_d;
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the
                // old path and is dropped on return.
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                discard_q  <= outst_d;
                fetch_pc_q <= redirect_pc;
                resp_pc_q  <= redirect_pc;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
                if (imem_rvalid && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
                if (grant) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (keep) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
            end
            // Remember the last delivered word so instr/instr_pc hold when empty.
            if (pop) begin
                last_instr_q <= mem_instr[rd_ptr_q];
                last_pc_q    <= mem_pc[rd_ptr_q];
            end else if (bypass_taken) begin
                last_instr_q <= imem_rdata;
                last_pc_q    <= resp_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr_q] <= imem_rdata;
            mem_pc[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule
